// File: rtl/eeprom_slave.sv
// rtl/eeprom_slave.sv - Two-wire serial EEPROM slave with internal byte memory
// Ports:
//   clk       system clock, rising edge, single clock domain
//   reset     asynchronous active-low reset
//   scl       serial clock from the master (no clock stretching)
//   sda       open-drain serial data; driven 0 or released, never driven 1
//   busy      high whenever the FSM is outside IDLE
//   wr_pulse  one-clk pulse per byte committed to memory
//   rd_pulse  one-clk pulse per byte loaded for transmission
module eeprom_slave #(
    parameter logic [3:0] DEV_ID    = 4'b1010,
    parameter int         ADDR_W    = 11,
    parameter int         MEM_DEPTH = 2048
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    inout  wire  sda,
    output logic busy,
    output logic wr_pulse,
    output logic rd_pulse
);

    typedef enum logic [3:0] {
        IDLE, CTRL, ACK_CTRL, ADDR, ACK_ADDR, WDATA, ACK_WDATA, RDATA, MACK, WAIT_STOP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        scl_sh;
    logic [2:0]        sda_sh;
    logic              scl_s;
    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic [3:0]        bit_cnt;
    logic              byte_done;
    logic [7:0]        shreg;
    logic [2:0]        addr_hi;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_byte;
    logic [7:0]        wr_byte;
    logic              mack_nack;
    logic              sda_oe;
    logic [7:0]        mem [MEM_DEPTH];

    // [1] is the synchronized value, [2] its previous sample for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], scl};
            sda_sh <= {sda_sh[1:0], sda};
        end
    end

    assign scl_s     = scl_sh[1];
    assign sda_s     = sda_sh[1];
    assign scl_rise  = scl_s & ~scl_sh[2];
    assign scl_fall  = ~scl_s & scl_sh[2];
    assign start_det = scl_s & scl_sh[2] & sda_sh[2] & ~sda_s;
    assign stop_det  = scl_s & scl_sh[2] & ~sda_sh[2] & sda_s;
    assign byte_done = (bit_cnt == 4'd8);

    assign ptr_inc = (ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
    // A master ACK reloads from the next location on the same falling edge.
    assign rd_addr = (state == MACK) ? ptr_inc : ptr;
    assign rd_byte = mem[rd_addr];
    assign wr_byte = {shreg[6:0], sda_s};

    // Gating with reset releases the line even before the flop clears.
    assign sda = (sda_oe && reset) ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (start_det) begin
            next_state = CTRL;
        end else if (stop_det) begin
            next_state = IDLE;
        end else begin
            case (state)
                CTRL:      if (scl_fall && byte_done)
                               next_state = (shreg[7:4] == DEV_ID) ? ACK_CTRL : WAIT_STOP;
                ACK_CTRL:  if (scl_fall) next_state = shreg[0] ? RDATA : ADDR;
                ADDR:      if (scl_fall && byte_done) next_state = ACK_ADDR;
                ACK_ADDR:  if (scl_fall) next_state = WDATA;
                WDATA:     if (scl_fall && byte_done) next_state = ACK_WDATA;
                ACK_WDATA: if (scl_fall) next_state = WDATA;
                RDATA:     if (scl_fall && byte_done) next_state = MACK;
                MACK:      if (scl_fall) next_state = mack_nack ? WAIT_STOP : RDATA;
                default:   next_state = state;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        // Commit on the 8th rising edge; a START/STOP in the same clk wins.
        wr_pulse = (state == WDATA) && scl_rise && (bit_cnt == 4'd7)
                   && !start_det && !stop_det;
        rd_pulse = scl_fall && !start_det && !stop_det &&
                   (((state == ACK_CTRL) && shreg[0]) || ((state == MACK) && !mack_nack));
    end

    always_ff @(posedge clk) begin
        if (wr_pulse) mem[ptr] <= wr_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            addr_hi   <= '0;
            ptr       <= '0;
            mack_nack <= 1'b1;
            sda_oe    <= 1'b0;
        end else if (start_det || stop_det) begin
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
        end else begin
            case (state)
                CTRL, ADDR, WDATA: begin
                    if (scl_rise && !byte_done) begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        bit_cnt <= '0;
                        // A foreign device code is answered by leaving sda released.
                        sda_oe  <= (state != CTRL) || (shreg[7:4] == DEV_ID);
                    end
                end
                ACK_CTRL: if (scl_fall) begin
                    if (shreg[0]) begin
                        shreg  <= rd_byte;
                        sda_oe <= ~rd_byte[7];
                    end else begin
                        addr_hi <= shreg[3:1];
                        sda_oe  <= 1'b0;
                    end
                end
                ACK_ADDR: if (scl_fall) begin
                    ptr    <= ADDR_W'({addr_hi, shreg});
                    sda_oe <= 1'b0;
                end
                ACK_WDATA: if (scl_fall) begin
                    ptr    <= ptr_inc;
                    sda_oe <= 1'b0;
                end
                RDATA: begin
                    if (scl_rise && !byte_done) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            bit_cnt   <= '0;
                            sda_oe    <= 1'b0;
                            mack_nack <= 1'b1;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        mack_nack <= sda_s;
                    end else if (scl_fall && !mack_nack) begin
                        ptr    <= ptr_inc;
                        shreg  <= rd_byte;
                        sda_oe <= ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
